// File: rtl/trap_unit.sv
`default_nettype none
// ============================================================================
//  Module      : trap_unit
//  Description : Machine-mode trap and CSR execution unit. Accepts one request
//                at a time from the issue stage, runs CSR read/modify/write,
//                trap entry or MRET, then writes rd back or redirects fetch.
//  Revision    : 1.0 - initial release
// ============================================================================
module trap_unit #(
    parameter logic [63:0] HART_ID     = 64'd0,
    parameter logic [63:0] MTVEC_RESET = 64'h0000_0000_8000_0000
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [63:0] ix_trap_pc,
    input  logic [4:0]  ix_trap_dst,
    input  logic [1:0]  ix_trap_csr_op,
    input  logic [11:0] ix_trap_csr_id,
    input  logic [63:0] ix_trap_csr_opr,
    input  logic        ix_trap_mret,
    input  logic        ix_trap_int,
    input  logic        ix_trap_intexc,
    input  logic [3:0]  ix_trap_cause,
    input  logic        ix_trap_valid,
    output logic        ix_trap_ready,
    output logic [15:0] trap_ix_ip,

    input  logic        ext_int,
    input  logic        tmr_int,
    input  logic        sw_int,

    output logic [4:0]  trap_wb_dst,
    output logic [63:0] trap_wb_result,
    output logic        trap_wb_wb_en,
    output logic        trap_wb_valid,

    output logic        trap_if_pc_override,
    output logic [63:0] trap_if_new_pc,
    output logic        trap_pipe_flush
);

    // CSR addresses
    localparam logic [11:0] c_CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] c_CSR_MIE      = 12'h304;
    localparam logic [11:0] c_CSR_MTVEC    = 12'h305;
    localparam logic [11:0] c_CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] c_CSR_MEPC     = 12'h341;
    localparam logic [11:0] c_CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] c_CSR_MIP      = 12'h344;
    localparam logic [11:0] c_CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] c_CSR_MHARTID  = 12'hF14;

    // CSR operation encodings
    localparam logic [1:0]  c_OP_NONE = 2'd0;
    localparam logic [1:0]  c_OP_RW   = 2'd1;
    localparam logic [1:0]  c_OP_RS   = 2'd2;
    localparam logic [1:0]  c_OP_RC   = 2'd3;

    // Only MEI/MTI/MSI exist in mip/mie
    localparam logic [15:0] c_INT_MASK = 16'h0888;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t       r_state;

    // Latched request
    logic [63:0]  r_pc;
    logic [4:0]   r_dst;
    logic [1:0]   r_csr_op;
    logic [11:0]  r_csr_id;
    logic [63:0]  r_csr_opr;
    logic         r_mret;
    logic         r_int;
    logic         r_intexc;
    logic [3:0]   r_cause;

    // Interrupt synchronizer: bit 2 = MEI, bit 1 = MTI, bit 0 = MSI
    logic [2:0]   r_int_meta;
    logic [2:0]   r_int_sync;

    // Architectural CSR state
    logic         r_mstatus_mie;
    logic         r_mstatus_mpie;
    logic [15:0]  r_mie;
    logic [63:0]  r_mtvec;
    logic [63:0]  r_mscratch;
    logic [63:0]  r_mepc;
    logic [63:0]  r_mcause;
    logic [63:0]  r_mcycle;

    // Derived values
    logic [63:0]  w_mip;
    logic [63:0]  w_mstatus;
    logic [63:0]  w_csr_rdata;
    logic [63:0]  w_csr_wdata;
    logic         w_exec;
    logic         w_is_trap;
    logic         w_is_mret;
    logic         w_is_csr;
    logic         w_csr_we;
    logic         w_mstatus_mie_nxt;
    logic         w_mstatus_mpie_nxt;
    logic [15:0]  w_mie_nxt;

    assign ix_trap_ready = rst & (r_state == S_IDLE);

    assign w_mip     = {52'd0, r_int_sync[2], 3'd0, r_int_sync[1], 3'd0, r_int_sync[0], 3'd0};
    assign w_mstatus = {51'd0, 2'b11, 3'd0, r_mstatus_mpie, 3'd0, r_mstatus_mie, 3'd0};

    assign w_exec    = (r_state == S_EXEC);
    assign w_is_trap = r_int;
    assign w_is_mret = ~r_int & r_mret;
    assign w_is_csr  = ~r_int & ~r_mret & (r_csr_op != c_OP_NONE);

    // Read mux for the latched CSR address
    always_comb begin
        w_csr_rdata = 64'd0;
        case (r_csr_id)
            c_CSR_MSTATUS:  w_csr_rdata = w_mstatus;
            c_CSR_MIE:      w_csr_rdata = {48'd0, r_mie};
            c_CSR_MTVEC:    w_csr_rdata = {r_mtvec[63:2], 2'b00};
            c_CSR_MSCRATCH: w_csr_rdata = r_mscratch;
            c_CSR_MEPC:     w_csr_rdata = {r_mepc[63:2], 2'b00};
            c_CSR_MCAUSE:   w_csr_rdata = r_mcause;
            c_CSR_MIP:      w_csr_rdata = w_mip;
            c_CSR_MCYCLE:   w_csr_rdata = r_mcycle;
            c_CSR_MHARTID:  w_csr_rdata = HART_ID;
            default:        w_csr_rdata = 64'd0;
        endcase
    end

    // Write data and enable; set/clear with a zero operand leave the CSR untouched
    always_comb begin
        w_csr_wdata = r_csr_opr;
        w_csr_we    = 1'b0;
        case (r_csr_op)
            c_OP_RW: begin
                w_csr_wdata = r_csr_opr;
                w_csr_we    = w_is_csr;
            end
            c_OP_RS: begin
                w_csr_wdata = w_csr_rdata | r_csr_opr;
                w_csr_we    = w_is_csr & (r_csr_opr != 64'd0);
            end
            c_OP_RC: begin
                w_csr_wdata = w_csr_rdata & ~r_csr_opr;
                w_csr_we    = w_is_csr & (r_csr_opr != 64'd0);
            end
            default: begin
                w_csr_wdata = r_csr_opr;
                w_csr_we    = 1'b0;
            end
        endcase
    end

    // Next interrupt-enable state, shared by the CSR registers and the ip output
    always_comb begin
        w_mstatus_mie_nxt  = r_mstatus_mie;
        w_mstatus_mpie_nxt = r_mstatus_mpie;
        w_mie_nxt          = r_mie;
        if (w_exec) begin
            if (w_is_trap) begin
                w_mstatus_mpie_nxt = r_mstatus_mie;
                w_mstatus_mie_nxt  = 1'b0;
            end else if (w_is_mret) begin
                w_mstatus_mie_nxt  = r_mstatus_mpie;
                w_mstatus_mpie_nxt = 1'b1;
            end else if (w_csr_we && r_csr_id == c_CSR_MSTATUS) begin
                w_mstatus_mie_nxt  = w_csr_wdata[3];
                w_mstatus_mpie_nxt = w_csr_wdata[7];
            end else if (w_csr_we && r_csr_id == c_CSR_MIE) begin
                w_mie_nxt = w_csr_wdata[15:0] & c_INT_MASK;
            end
        end
    end

    // Two-flop synchronizer for the asynchronous interrupt lines
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_int_meta <= 3'd0;
            r_int_sync <= 3'd0;
        end else begin
            r_int_meta <= {ext_int, tmr_int, sw_int};
            r_int_sync <= r_int_meta;
        end
    end

    // Enabled pending mask, built from the post-commit enables so a taken trap masks it in RESP
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            trap_ix_ip <= 16'd0;
        end else begin
            trap_ix_ip <= w_mstatus_mie_nxt ? (w_mip[15:0] & w_mie_nxt & c_INT_MASK) : 16'd0;
        end
    end

    // CSR state update: commits happen only on the closing edge of EXEC
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mstatus_mie  <= 1'b0;
            r_mstatus_mpie <= 1'b0;
            r_mie          <= 16'd0;
            r_mtvec        <= {MTVEC_RESET[63:2], 2'b00};
            r_mscratch     <= 64'd0;
            r_mepc         <= 64'd0;
            r_mcause       <= 64'd0;
            r_mcycle       <= 64'd0;
        end else begin
            r_mstatus_mie  <= w_mstatus_mie_nxt;
            r_mstatus_mpie <= w_mstatus_mpie_nxt;
            r_mie          <= w_mie_nxt;

            if (w_exec && w_csr_we && r_csr_id == c_CSR_MCYCLE) begin
                r_mcycle <= w_csr_wdata;
            end else begin
                r_mcycle <= r_mcycle + 64'd1;
            end

            if (w_exec && w_is_trap) begin
                r_mepc   <= {r_pc[63:2], 2'b00};
                r_mcause <= {r_intexc, 59'd0, r_cause};
            end else if (w_exec && w_csr_we) begin
                case (r_csr_id)
                    c_CSR_MTVEC:    r_mtvec    <= {w_csr_wdata[63:2], 2'b00};
                    c_CSR_MSCRATCH: r_mscratch <= w_csr_wdata;
                    c_CSR_MEPC:     r_mepc     <= {w_csr_wdata[63:2], 2'b00};
                    c_CSR_MCAUSE:   r_mcause   <= w_csr_wdata;
                    default: ;
                endcase
            end
        end
    end

    // Request FSM with registered writeback and redirect outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state             <= S_IDLE;
            r_pc                <= 64'd0;
            r_dst               <= 5'd0;
            r_csr_op            <= c_OP_NONE;
            r_csr_id            <= 12'd0;
            r_csr_opr           <= 64'd0;
            r_mret              <= 1'b0;
            r_int               <= 1'b0;
            r_intexc            <= 1'b0;
            r_cause             <= 4'd0;
            trap_wb_dst         <= 5'd0;
            trap_wb_result      <= 64'd0;
            trap_wb_wb_en       <= 1'b0;
            trap_wb_valid       <= 1'b0;
            trap_if_pc_override <= 1'b0;
            trap_if_new_pc      <= 64'd0;
            trap_pipe_flush     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (ix_trap_valid) begin
                        r_pc      <= ix_trap_pc;
                        r_dst     <= ix_trap_dst;
                        r_csr_op  <= ix_trap_csr_op;
                        r_csr_id  <= ix_trap_csr_id;
                        r_csr_opr <= ix_trap_csr_opr;
                        r_mret    <= ix_trap_mret;
                        r_int     <= ix_trap_int;
                        r_intexc  <= ix_trap_intexc;
                        r_cause   <= ix_trap_cause;
                        r_state   <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_state <= S_RESP;
                    if (w_is_trap) begin
                        trap_if_pc_override <= 1'b1;
                        trap_pipe_flush     <= 1'b1;
                        trap_if_new_pc      <= {r_mtvec[63:2], 2'b00};
                    end else if (w_is_mret) begin
                        trap_if_pc_override <= 1'b1;
                        trap_pipe_flush     <= 1'b1;
                        trap_if_new_pc      <= {r_mepc[63:2], 2'b00};
                    end else if (w_is_csr) begin
                        trap_wb_valid  <= 1'b1;
                        trap_wb_wb_en  <= (r_dst != 5'd0);
                        trap_wb_dst    <= r_dst;
                        trap_wb_result <= w_csr_rdata;
                    end
                end
                S_RESP: begin
                    r_state             <= S_IDLE;
                    trap_wb_valid       <= 1'b0;
                    trap_wb_wb_en       <= 1'b0;
                    trap_if_pc_override <= 1'b0;
                    trap_pipe_flush     <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_trap_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_trap_unit
//  Description : Directed self-checking bench for trap_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_trap_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] ix_trap_pc;
    logic [4:0]  ix_trap_dst;
    logic [1:0]  ix_trap_csr_op;
    logic [11:0] ix_trap_csr_id;
    logic [63:0] ix_trap_csr_opr;
    logic        ix_trap_mret;
    logic        ix_trap_int;
    logic        ix_trap_intexc;
    logic [3:0]  ix_trap_cause;
    logic        ix_trap_valid;
    logic        ix_trap_ready;
    logic [15:0] trap_ix_ip;
    logic        ext_int;
    logic        tmr_int;
    logic        sw_int;
    logic [4:0]  trap_wb_dst;
    logic [63:0] trap_wb_result;
    logic        trap_wb_wb_en;
    logic        trap_wb_valid;
    logic        trap_if_pc_override;
    logic [63:0] trap_if_new_pc;
    logic        trap_pipe_flush;

    int checks = 0;
    int errors = 0;

    // Values captured in the RESP cycle and the cycle after
    logic        s_wb_valid, s_wb_en, s_ovr, s_flush, s_ready_after;
    logic [4:0]  s_dst;
    logic [63:0] s_result, s_new_pc;
    logic [15:0] s_ip;

    trap_unit #(
        .HART_ID     (64'd0),
        .MTVEC_RESET (64'h0000_0000_8000_0000)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .ix_trap_pc          (ix_trap_pc),
        .ix_trap_dst         (ix_trap_dst),
        .ix_trap_csr_op      (ix_trap_csr_op),
        .ix_trap_csr_id      (ix_trap_csr_id),
        .ix_trap_csr_opr     (ix_trap_csr_opr),
        .ix_trap_mret        (ix_trap_mret),
        .ix_trap_int         (ix_trap_int),
        .ix_trap_intexc      (ix_trap_intexc),
        .ix_trap_cause       (ix_trap_cause),
        .ix_trap_valid       (ix_trap_valid),
        .ix_trap_ready       (ix_trap_ready),
        .trap_ix_ip          (trap_ix_ip),
        .ext_int             (ext_int),
        .tmr_int             (tmr_int),
        .sw_int              (sw_int),
        .trap_wb_dst         (trap_wb_dst),
        .trap_wb_result      (trap_wb_result),
        .trap_wb_wb_en       (trap_wb_wb_en),
        .trap_wb_valid       (trap_wb_valid),
        .trap_if_pc_override (trap_if_pc_override),
        .trap_if_new_pc      (trap_if_new_pc),
        .trap_pipe_flush     (trap_pipe_flush)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one request at a negedge and capture RESP (T+2) and T+3 outputs
    task automatic send(input logic [63:0] pc, input logic [4:0] dst, input logic [1:0] op,
                        input logic [11:0] id, input logic [63:0] opr, input logic mret,
                        input logic trp, input logic intexc, input logic [3:0] cause);
        int n;
        n = 0;
        while (ix_trap_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n != 0) chk("ready_wait", {63'd0, ix_trap_ready}, 64'd1);
        ix_trap_pc      = pc;
        ix_trap_dst     = dst;
        ix_trap_csr_op  = op;
        ix_trap_csr_id  = id;
        ix_trap_csr_opr = opr;
        ix_trap_mret    = mret;
        ix_trap_int     = trp;
        ix_trap_intexc  = intexc;
        ix_trap_cause   = cause;
        ix_trap_valid   = 1'b1;
        @(negedge clk);
        ix_trap_valid   = 1'b0;
        @(negedge clk);
        s_wb_valid = trap_wb_valid;
        s_wb_en    = trap_wb_wb_en;
        s_dst      = trap_wb_dst;
        s_result   = trap_wb_result;
        s_ovr      = trap_if_pc_override;
        s_flush    = trap_pipe_flush;
        s_new_pc   = trap_if_new_pc;
        s_ip       = trap_ix_ip;
        @(negedge clk);
        s_ready_after = ix_trap_ready;
    endtask

    task automatic csr(input logic [1:0] op, input logic [11:0] id, input logic [63:0] opr,
                       input logic [4:0] dst);
        send(64'd0, dst, op, id, opr, 1'b0, 1'b0, 1'b0, 4'd0);
    endtask

    initial begin
        rst = 1'b0;
        ix_trap_pc = '0; ix_trap_dst = '0; ix_trap_csr_op = '0; ix_trap_csr_id = '0;
        ix_trap_csr_opr = '0; ix_trap_mret = 1'b0; ix_trap_int = 1'b0; ix_trap_intexc = 1'b0;
        ix_trap_cause = '0; ix_trap_valid = 1'b0;
        ext_int = 1'b0; tmr_int = 1'b0; sw_int = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", {63'd0, ix_trap_ready}, 64'd0);
        chk("rst_wb_valid", {63'd0, trap_wb_valid}, 64'd0);
        chk("rst_override", {63'd0, trap_if_pc_override}, 64'd0);
        chk("rst_flush", {63'd0, trap_pipe_flush}, 64'd0);
        chk("rst_ip", {48'd0, trap_ix_ip}, 64'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", {63'd0, ix_trap_ready}, 64'd1);

        // Reset values of read-only / fixed CSRs
        csr(2'd2, 12'h305, 64'd0, 5'd1);
        chk("mtvec_reset", s_result, 64'h0000_0000_8000_0000);
        csr(2'd2, 12'hF14, 64'd0, 5'd1);
        chk("mhartid", s_result, 64'd0);
        csr(2'd2, 12'h300, 64'd0, 5'd1);
        chk("mstatus_reset", s_result, 64'h1800);

        // CSR RW on mscratch
        csr(2'd1, 12'h340, 64'h1234, 5'd0);
        csr(2'd1, 12'h340, 64'hABCD, 5'd5);
        chk("rw_wb_valid", {63'd0, s_wb_valid}, 64'd1);
        chk("rw_wb_en", {63'd0, s_wb_en}, 64'd1);
        chk("rw_dst", {59'd0, s_dst}, 64'd5);
        chk("rw_result", s_result, 64'h1234);
        chk("rw_no_override", {63'd0, s_ovr}, 64'd0);
        chk("rw_ready_t3", {63'd0, s_ready_after}, 64'd1);
        csr(2'd2, 12'h340, 64'd0, 5'd1);
        chk("mscratch_read", s_result, 64'hABCD);

        // RS / RC on mie with rd = x0
        csr(2'd2, 12'h304, 64'h888, 5'd0);
        chk("rs_wb_valid", {63'd0, s_wb_valid}, 64'd1);
        chk("rs_wb_en", {63'd0, s_wb_en}, 64'd0);
        chk("rs_result", s_result, 64'd0);
        csr(2'd3, 12'h304, 64'h8, 5'd0);
        chk("rc_wb_en", {63'd0, s_wb_en}, 64'd0);
        chk("rc_result", s_result, 64'h888);
        csr(2'd2, 12'h304, 64'd0, 5'd1);
        chk("mie_read", s_result, 64'h880);

        // Unmapped and read-only addresses
        csr(2'd1, 12'h7C0, 64'hFFFF, 5'd1);
        csr(2'd2, 12'h7C0, 64'd0, 5'd1);
        chk("unmapped_read", s_result, 64'd0);
        csr(2'd1, 12'h344, 64'hFFFF, 5'd1);
        csr(2'd2, 12'h344, 64'd0, 5'd1);
        chk("mip_readonly", s_result, 64'd0);

        // Exception entry
        csr(2'd1, 12'h305, 64'h8000_0101, 5'd0);
        csr(2'd2, 12'h305, 64'd0, 5'd1);
        chk("mtvec_low_bits", s_result, 64'h8000_0100);
        csr(2'd1, 12'h300, 64'h8, 5'd0);
        csr(2'd2, 12'h300, 64'd0, 5'd1);
        chk("mstatus_mie_set", s_result, 64'h1808);
        send(64'h8000_0042, 5'd0, 2'd0, 12'd0, 64'd0, 1'b0, 1'b1, 1'b0, 4'd11);
        chk("exc_override", {63'd0, s_ovr}, 64'd1);
        chk("exc_flush", {63'd0, s_flush}, 64'd1);
        chk("exc_new_pc", s_new_pc, 64'h8000_0100);
        chk("exc_no_wb", {63'd0, s_wb_valid}, 64'd0);
        csr(2'd2, 12'h341, 64'd0, 5'd1);
        chk("exc_mepc", s_result, 64'h8000_0040);
        csr(2'd2, 12'h342, 64'd0, 5'd1);
        chk("exc_mcause", s_result, 64'hB);
        csr(2'd2, 12'h300, 64'd0, 5'd1);
        chk("exc_mstatus", s_result, 64'h1880);

        // Interrupt entry
        csr(2'd1, 12'h304, 64'h080, 5'd0);
        csr(2'd1, 12'h300, 64'h8, 5'd0);
        tmr_int = 1'b1;
        repeat (3) @(negedge clk);
        chk("ip_timer", {48'd0, trap_ix_ip}, 64'h0080);
        send(64'h8000_2000, 5'd0, 2'd0, 12'd0, 64'd0, 1'b0, 1'b1, 1'b1, 4'd7);
        chk("int_override", {63'd0, s_ovr}, 64'd1);
        chk("int_new_pc", s_new_pc, 64'h8000_0100);
        chk("int_ip_resp", {48'd0, s_ip}, 64'd0);
        csr(2'd2, 12'h342, 64'd0, 5'd1);
        chk("int_mcause", s_result, 64'h8000_0000_0000_0007);
        csr(2'd2, 12'h300, 64'd0, 5'd1);
        chk("int_mstatus", s_result, 64'h1880);

        // MRET
        send(64'd0, 5'd0, 2'd0, 12'd0, 64'd0, 1'b1, 1'b0, 1'b0, 4'd0);
        chk("mret_override", {63'd0, s_ovr}, 64'd1);
        chk("mret_flush", {63'd0, s_flush}, 64'd1);
        chk("mret_new_pc", s_new_pc, 64'h8000_2000);
        chk("mret_ip_resp", {48'd0, s_ip}, 64'h0080);
        csr(2'd2, 12'h300, 64'd0, 5'd1);
        chk("mret_mstatus", s_result, 64'h1888);

        // mcycle write then read three cycles later in EXEC
        csr(2'd1, 12'hB00, 64'd100, 5'd0);
        csr(2'd2, 12'hB00, 64'd0, 5'd1);
        chk("mcycle_count", s_result, 64'd102);

        // Request with no action
        send(64'd0, 5'd4, 2'd0, 12'h340, 64'd0, 1'b0, 1'b0, 1'b0, 4'd0);
        chk("noop_wb_valid", {63'd0, s_wb_valid}, 64'd0);
        chk("noop_override", {63'd0, s_ovr}, 64'd0);

        // Reset pulse during EXEC
        ix_trap_pc = '0; ix_trap_dst = 5'd3; ix_trap_csr_op = 2'd1; ix_trap_csr_id = 12'h340;
        ix_trap_csr_opr = 64'h5555; ix_trap_mret = 1'b0; ix_trap_int = 1'b0;
        ix_trap_valid = 1'b1;
        @(negedge clk);
        ix_trap_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("midrst_ready", {63'd0, ix_trap_ready}, 64'd0);
        @(negedge clk);
        chk("midrst_wb_valid", {63'd0, trap_wb_valid}, 64'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_ready_after", {63'd0, ix_trap_ready}, 64'd1);
        chk("midrst_no_wb", {63'd0, trap_wb_valid}, 64'd0);
        csr(2'd2, 12'h340, 64'd0, 5'd1);
        chk("midrst_mscratch", s_result, 64'd0);
        chk("midrst_ip", {48'd0, s_ip}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
